// File: rtl/rom_reader_if.sv
// ROM read bus between the sweep initiator (master) and a registered,
// one-hot-addressed ROM (slave). The ROM returns data one cycle after rom_en.
interface rom_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_en, rom_addr, input rom_data);
  modport slave  (input rom_en, rom_addr, output rom_data);
endinterface

// File: rtl/rom_reader.sv
// Sweeps NUM_ENTRIES one-hot ROM addresses back to back, streams each returned
// byte downstream with its index, and keeps a running sum of the sweep.
module rom_reader #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int ADDR_W      = 8,
  parameter  int DATA_W      = 8,
  parameter  int SUM_W       = DATA_W + 3,
  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  rom_reader_if.master       rom,
  output logic [DATA_W-1:0]  byte_out,
  output logic               byte_valid,
  output logic [IDX_W-1:0]   byte_idx,
  output logic [SUM_W-1:0]   sum,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [1:0]        state_q,      state_d;
  logic [IDX_W-1:0]  issue_idx_q,  issue_idx_d;
  logic [IDX_W-1:0]  cap_idx_q,    cap_idx_d;
  logic              pending_q,    pending_d;
  logic              rom_en_q,     rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
  logic [DATA_W-1:0] byte_out_q,   byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic [IDX_W-1:0]  byte_idx_q,   byte_idx_d;
  logic [SUM_W-1:0]  sum_q,        sum_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;

  logic              do_issue;
  logic [IDX_W-1:0]  issue_sel;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    state_d      = state_q;
    issue_idx_d  = issue_idx_q;
    cap_idx_d    = cap_idx_q;
    pending_d    = rom_en_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = '0;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_idx_d   = byte_idx_q;
    sum_d        = sum_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    do_issue     = 1'b0;
    issue_sel    = issue_idx_q;

    // Captures are driven purely by the pending pipeline, independent of pause.
    if (pending_q) begin
      byte_out_d   = rom.rom_data;
      byte_idx_d   = cap_idx_q;
      cap_idx_d    = cap_idx_q + IDX_W'(1);
      byte_valid_d = 1'b1;
      sum_d        = sum_q + SUM_W'(rom.rom_data);
      done_d       = (cap_idx_q == LAST_IDX);
    end

    case (state_q)
      ST_IDLE: begin
        // Entry 0 goes out on the accepting edge so rom_en rises with busy.
        if (start) begin
          do_issue    = 1'b1;
          issue_sel   = '0;
          sum_d       = '0;
          cap_idx_d   = '0;
          busy_d      = 1'b1;
          issue_idx_d = IDX_W'(1);
          state_d     = (LAST_IDX == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!pause) begin
          do_issue    = 1'b1;
          issue_idx_d = issue_idx_q + IDX_W'(1);
          if (issue_idx_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_issue) begin
      rom_en_d   = 1'b1;
      rom_addr_d = ADDR_W'(1) << issue_sel;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  // NOTE: the datapath registers are reset along with control because the
  // outputs must read as zero straight after reset, not just be ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_idx_q  <= '0;
      cap_idx_q    <= '0;
      pending_q    <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      sum_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_idx_q  <= issue_idx_d;
      cap_idx_q    <= cap_idx_d;
      pending_q    <= pending_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_idx_q   <= byte_idx_d;
      sum_q        <= sum_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = rom_addr_q;
  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign byte_idx     = byte_idx_q;
  assign sum          = sum_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: an 8-entry and a 1-entry reader share one ROM image;
// expected timing and data come from an issue-schedule model of pause/start.
module tb_rom_reader;

  localparam int N  = 8;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = DW + 3;

  logic clk = 1'b0;
  logic rst, start, start1, pause;
  always #5 clk = ~clk;

  rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) rom_bus  ();
  rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) rom_bus1 ();

  logic [DW-1:0] byte_out,  byte_out1;
  logic          byte_valid, byte_valid1;
  logic [2:0]    byte_idx;
  logic [0:0]    byte_idx1;
  logic [SW-1:0] sum, sum1;
  logic          busy, busy1, done, done1;

  rom_reader #(.NUM_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .rom(rom_bus),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_idx(byte_idx),
    .sum(sum), .busy(busy), .done(done)
  );

  rom_reader #(.NUM_ENTRIES(1), .ADDR_W(AW), .DATA_W(DW), .SUM_W(SW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pause(pause), .rom(rom_bus1),
    .byte_out(byte_out1), .byte_valid(byte_valid1), .byte_idx(byte_idx1),
    .sum(sum1), .busy(busy1), .done(done1)
  );

  // Registered one-hot ROM shared by both readers.
  logic [DW-1:0] mem [0:AW-1];

  function automatic int oh_idx(input logic [AW-1:0] a);
    oh_idx = 0;
    for (int i = 0; i < AW; i++) if (a[i]) oh_idx = i;
  endfunction

  always @(posedge clk) begin
    if (rom_bus.rom_en)  rom_bus.rom_data  <= mem[oh_idx(rom_bus.rom_addr)];
    if (rom_bus1.rom_en) rom_bus1.rom_data <= mem[oh_idx(rom_bus1.rom_addr)];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; int idx; } ev_t;
  ev_t en_q[$], bv_q[$], en1_q[$], bv1_q[$];
  int done_cnt, done_cyc, done_sum, busy_last, busy_first, sum_first, addr_bad;
  int done1_cnt, done1_cyc, busy1_cnt;
  int s_cyc;
  int n_tests = 0;
  int n_fail  = 0;
  bit pause_pat [0:63];
  bit start_pat [0:63];

  // Monitor: records events tagged with their cycle number (cycle s+1 follows edge s).
  always @(negedge clk) begin
    int c;
    c = cyc + 1;
    if (rom_bus.rom_en) en_q.push_back('{c, int'(rom_bus.rom_addr), 0});
    else if (rom_bus.rom_addr !== '0) addr_bad++;
    if (byte_valid) bv_q.push_back('{c, int'(byte_out), int'(byte_idx)});
    if (done) begin done_cnt++; done_cyc = c; done_sum = int'(sum); end
    if (busy) begin
      busy_last = c;
      if (busy_first == 0) begin busy_first = c; sum_first = int'(sum); end
    end
    if (rom_bus1.rom_en) en1_q.push_back('{c, int'(rom_bus1.rom_addr), 0});
    if (byte_valid1) bv1_q.push_back('{c, int'(byte_out1), int'(byte_idx1)});
    if (done1) begin done1_cnt++; done1_cyc = c; end
    if (busy1) busy1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    en_q.delete(); bv_q.delete(); en1_q.delete(); bv1_q.delete();
    done_cnt = 0; done_cyc = 0; done_sum = 0; busy_last = 0; busy_first = 0;
    sum_first = -1; addr_bad = 0; done1_cnt = 0; done1_cyc = 0; busy1_cnt = 0;
  endtask

  // Pulse start, then drive pause_pat/start_pat for cycles s+1..s+n.
  task automatic run_sweep(input int n);
    clear_mon();
    start = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    s_cyc = cyc; start = 1'b0; start1 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      pause = pause_pat[k];
      start = start_pat[k];
      @(posedge clk); #1;
    end
    pause = 1'b0; start = 1'b0;
  endtask

  // Reference: entry 0 appears in cycle s+1; each later entry appears the cycle
  // after the first non-paused cycle at or after the previous issue. Data
  // follows two cycles behind each issue; done rides on the last byte.
  task automatic check_sweep(input string tag);
    int iss [N];
    int c, exp_sum;
    iss[0] = 1;
    for (int i = 1; i < N; i++) begin
      c = iss[i-1];
      while (c < 63 && pause_pat[c]) c++;
      iss[i] = c + 1;
    end
    exp_sum = 0;
    for (int i = 0; i < N; i++) exp_sum += int'(mem[i]);

    check({tag, ".n_en"}, en_q.size(), N);
    for (int i = 0; i < N && i < en_q.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), en_q[i].val, 1 << i);
      check($sformatf("%s.en_cyc%0d", tag, i), en_q[i].cyc - s_cyc, iss[i]);
    end
    check({tag, ".n_bv"}, bv_q.size(), N);
    for (int i = 0; i < N && i < bv_q.size(); i++) begin
      check($sformatf("%s.byte%0d", tag, i), bv_q[i].val, int'(mem[i]));
      check($sformatf("%s.idx%0d", tag, i), bv_q[i].idx, i);
      check($sformatf("%s.bv_cyc%0d", tag, i), bv_q[i].cyc - s_cyc, iss[i] + 2);
    end
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".done_cyc"}, done_cyc - s_cyc, iss[N-1] + 2);
    check({tag, ".done_sum"}, done_sum, exp_sum);
    check({tag, ".busy_first"}, busy_first - s_cyc, 1);
    check({tag, ".busy_last"}, busy_last - s_cyc, iss[N-1] + 2);
    check({tag, ".sum_hold"}, sum, exp_sum);
    check({tag, ".addr_idle0"}, addr_bad, 0);
    check({tag, ".n1_en"}, en1_q.size(), 1);
    if (en1_q.size() > 0) begin
      check({tag, ".n1_addr"}, en1_q[0].val, 1);
      check({tag, ".n1_en_cyc"}, en1_q[0].cyc - s_cyc, 1);
    end
    check({tag, ".n1_bv"}, bv1_q.size(), 1);
    if (bv1_q.size() > 0) begin
      check({tag, ".n1_byte"}, bv1_q[0].val, int'(mem[0]));
      check({tag, ".n1_bv_cyc"}, bv1_q[0].cyc - s_cyc, 3);
    end
    check({tag, ".n1_done_cnt"}, done1_cnt, 1);
    check({tag, ".n1_done_cyc"}, done1_cyc - s_cyc, 3);
    check({tag, ".n1_busy_cnt"}, busy1_cnt, 3);
    check({tag, ".n1_sum"}, sum1, int'(mem[0]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rom_en"},     rom_bus.rom_en, 0);
    check({tag, ".rom_addr"},   rom_bus.rom_addr, 0);
    check({tag, ".byte_out"},   byte_out, 0);
    check({tag, ".byte_valid"}, byte_valid, 0);
    check({tag, ".byte_idx"},   byte_idx, 0);
    check({tag, ".sum"},        sum, 0);
    check({tag, ".busy"},       busy, 0);
    check({tag, ".done"},       done, 0);
    check({tag, ".n1_busy"},    busy1, 0);
    check({tag, ".n1_rom_en"},  rom_bus1.rom_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; pause = 1'b0;
    mem = '{8'h22, 8'h23, 8'h32, 8'h33, 8'h72, 8'h39, 8'h76, 8'hB3};
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal sweep.
    run_sweep(14);
    check_sweep("nom");
    check("nom.sum_27e", sum, 32'h27E);

    // Pause for 3 cycles right after entry 2 is issued (cycle s+3).
    pause_pat[3] = 1'b1; pause_pat[4] = 1'b1; pause_pat[5] = 1'b1;
    run_sweep(17);
    check_sweep("pause");
    check("pause.done_s13", done_cyc - s_cyc, 13);
    if (en_q.size() > 3) check("pause.gap", en_q[3].cyc - en_q[2].cyc, 4);
    for (int k = 0; k < 64; k++) pause_pat[k] = 1'b0;

    // start re-pulsed mid-sweep and in the done cycle; then one cycle after done.
    start_pat[4] = 1'b1; start_pat[10] = 1'b1;
    run_sweep(10);
    check("rep.busy_s11", busy, 0);
    check_sweep("rep");
    for (int k = 0; k < 64; k++) start_pat[k] = 1'b0;
    run_sweep(14);
    check("rep2.sum_cleared", sum_first, 0);
    check_sweep("rep2");

    // Reset asserted in cycle s+5.
    clear_mon();
    start = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    s_cyc = cyc; start = 1'b0; start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst.bv_before", bv_q.size(), 3);
    check_zero("rst_mid");
    clear_mon();
    repeat (8) @(posedge clk);
    #1;
    check("rst.no_bv", bv_q.size(), 0);
    check("rst.no_en", en_q.size(), 0);
    run_sweep(14);
    check_sweep("post_rst");

    // All-FF ROM: largest sum, no wrap.
    for (int i = 0; i < AW; i++) mem[i] = 8'hFF;
    run_sweep(14);
    check_sweep("ff");
    check("ff.sum_7f8", sum, 32'h7F8);

    // Random contents and random pause patterns.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < AW; i++) mem[i] = DW'($urandom_range(0, 255));
      for (int k = 1; k <= 20; k++) pause_pat[k] = ($urandom_range(0, 2) == 0);
      run_sweep(36);
      check_sweep($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
